// File: rtl/cpu_control.sv
// cpu_control: multi-cycle FETCH/DECODE/EXEC/MEM sequencer driving the datapath controls.
// Build option: define CPU_CTRL_ILLEGAL_TRAP_EN to halt on illegal opcodes instead of running them as NOPs.
module cpu_control #(
  parameter int NIB_WIDTH    = 4,
  parameter int RETIRE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NIB_WIDTH-1:0]    opcode,
  input  logic                    isaluop,
  input  logic [2:0]              aluop,
  input  logic                    rd1_zero,
  input  logic                    mem_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic                    mem_addr_sel,
  output logic                    ir_load,
  output logic                    pc_en,
  output logic [1:0]              pc_sel,
  output logic                    reg_we,
  output logic [1:0]              reg_wsel,
  output logic                    alu_en,
  output logic [2:0]              alu_func,
  output logic                    halted,
  output logic                    illegal,
  output logic [RETIRE_WIDTH-1:0] retired,
  output logic [2:0]              state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  localparam logic [NIB_WIDTH-1:0] OP_LDI  = NIB_WIDTH'(8);
  localparam logic [NIB_WIDTH-1:0] OP_LD   = NIB_WIDTH'(9);
  localparam logic [NIB_WIDTH-1:0] OP_ST   = NIB_WIDTH'(10);
  localparam logic [NIB_WIDTH-1:0] OP_BZ   = NIB_WIDTH'(11);
  localparam logic [NIB_WIDTH-1:0] OP_JMP  = NIB_WIDTH'(12);
  localparam logic [NIB_WIDTH-1:0] OP_HALT = NIB_WIDTH'(13);

  state_e                  state_q, state_d;
  logic [RETIRE_WIDTH-1:0] retired_q;
  logic                    illegal_q;
  logic                    retire;
  logic                    ill_set;
  logic                    is_ld, is_st;

  assign is_ld     = (opcode == OP_LD);
  assign is_st     = (opcode == OP_ST);
  assign retired   = retired_q;
  assign illegal   = illegal_q;
  assign state_dbg = state_q;

  // Memory handshake: mem_req/mem_we/mem_addr_sel depend only on state, so they hold
  // steady until a cycle with mem_req=1 and mem_ready=1, which completes the access.
  // While rst_n is low every control is forced to 0 so an in-flight access is abandoned.
  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    ill_set      = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_en        = 1'b0;
    pc_sel       = 2'd0;
    reg_we       = 1'b0;
    reg_wsel     = 2'd0;
    alu_en       = 1'b0;
    alu_func     = 3'd0;
    halted       = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_load = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: state_d = S_EXEC;
        S_EXEC: begin
          if (isaluop) begin
            alu_en   = 1'b1;
            alu_func = aluop;
            reg_we   = 1'b1;
            pc_en    = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end else begin
            case (opcode)
              OP_LDI: begin
                reg_we   = 1'b1;
                reg_wsel = 2'd1;
                pc_en    = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
              end
              OP_LD, OP_ST: state_d = S_MEM;
              OP_BZ: begin
                pc_en   = 1'b1;
                pc_sel  = rd1_zero ? 2'd1 : 2'd0;
                retire  = 1'b1;
                state_d = S_FETCH;
              end
              OP_JMP: begin
                pc_en   = 1'b1;
                pc_sel  = 2'd2;
                retire  = 1'b1;
                state_d = S_FETCH;
              end
              OP_HALT: begin
                retire  = 1'b1;
                state_d = S_HALT;
              end
              default: begin
                ill_set = 1'b1;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                state_d = S_HALT;
`else
                pc_en   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
`endif
              end
            endcase
          end
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = is_st;
          if (mem_ready) begin
            reg_we   = is_ld;
            reg_wsel = is_ld ? 2'd2 : 2'd0;
            pc_en    = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
        end
        S_HALT:  halted = 1'b1;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire)  retired_q <= retired_q + RETIRE_WIDTH'(1);
      if (ill_set) illegal_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_control.sv
// tb_cpu_control: instruction-level randomized bench for cpu_control with a per-cycle expected queue.
// Honours CPU_CTRL_ILLEGAL_TRAP_EN the same way as the design build.
module tb_cpu_control;
  localparam int RW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    opcode;
  logic          isaluop;
  logic [2:0]    aluop;
  logic          rd1_zero;
  logic          mem_ready;
  logic          mem_req, mem_we, mem_addr_sel, ir_load, pc_en, reg_we, alu_en, halted, illegal;
  logic [1:0]    pc_sel, reg_wsel;
  logic [2:0]    alu_func, state_dbg;
  logic [RW-1:0] retired;
  logic [14:0]   got_vec;

  int            total = 0;
  int            bad   = 0;
  logic [RW-1:0] exp_ret;
  logic          exp_ill;
  // entry = {sets_illegal, retires, mem_ready to drive, expected control vector}
  logic [17:0]   exp_q[$];

  always #5 clk = ~clk;

  cpu_control #(.NIB_WIDTH(4), .RETIRE_WIDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .isaluop(isaluop), .aluop(aluop),
    .rd1_zero(rd1_zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_load(ir_load), .pc_en(pc_en), .pc_sel(pc_sel),
    .reg_we(reg_we), .reg_wsel(reg_wsel), .alu_en(alu_en), .alu_func(alu_func),
    .halted(halted), .illegal(illegal), .retired(retired), .state_dbg(state_dbg)
  );

  assign got_vec = {mem_req, mem_we, mem_addr_sel, ir_load, pc_en, pc_sel,
                    reg_we, reg_wsel, alu_en, alu_func, halted};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] mk(input logic mreq, input logic mwe, input logic masel,
                                     input logic irl, input logic pce, input logic [1:0] pcs,
                                     input logic rwe, input logic [1:0] rws, input logic alue,
                                     input logic [2:0] aluf, input logic hlt);
    return {mreq, mwe, masel, irl, pce, pcs, rwe, rws, alue, aluf, hlt};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic rdy, input logic [14:0] v, input logic ret, input logic ill);
    exp_q.push_back({ill, ret, rdy, v});
  endfunction

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic do_cycle(input logic [17:0] e);
    mem_ready = e[15];
    #1;
    chk("outs", 32'(got_vec), 32'(e[14:0]));
    chk("retired", 32'(retired), 32'(exp_ret));
    chk("illegal", 32'(illegal), 32'(exp_ill));
    if (e[16]) exp_ret = exp_ret + 1'b1;
    if (e[17]) exp_ill = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) do_cycle(exp_q.pop_front());
  endtask

  task automatic do_reset(input logic rdy);
    rst_n = 1'b0;
    mem_ready = rdy;
    #1;
    chk("rst_outs", 32'(got_vec), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_outs2", 32'(got_vec), 32'd0);
    exp_ret = '0;
    exp_ill = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Queue fetch, decode and exec (plus MEM for LD/ST) of one instruction.
  task automatic queue_instr(input logic [3:0] op, input int fw, input int mw, input logic z,
                             input bit finish_mem);
    logic ld, st;
    ld = (op == 4'd9);
    st = (op == 4'd10);
    opcode   = op;
    isaluop  = (op < 4'd8);
    aluop    = (op < 4'd8) ? op[2:0] : 3'($urandom_range(0, 7));
    rd1_zero = z;
    for (int i = 0; i < fw; i++) push(1'b0, mk(1,0,0,0,0,2'd0,0,2'd0,0,3'd0,0), 1'b0, 1'b0);
    push(1'b1, mk(1,0,0,1,0,2'd0,0,2'd0,0,3'd0,0), 1'b0, 1'b0);
    push(rb(), 15'd0, 1'b0, 1'b0);
    if (op < 4'd8) push(rb(), mk(0,0,0,0,1,2'd0,1,2'd0,1,op[2:0],0), 1'b1, 1'b0);
    else begin
      case (op)
        4'd8:  push(rb(), mk(0,0,0,0,1,2'd0,1,2'd1,0,3'd0,0), 1'b1, 1'b0);
        4'd9, 4'd10: begin
          push(rb(), 15'd0, 1'b0, 1'b0);
          for (int i = 0; i < mw; i++) push(1'b0, mk(1,st,1,0,0,2'd0,0,2'd0,0,3'd0,0), 1'b0, 1'b0);
          if (finish_mem)
            push(1'b1, mk(1,st,1,0,1,2'd0,ld,(ld ? 2'd2 : 2'd0),0,3'd0,0), 1'b1, 1'b0);
        end
        4'd11: push(rb(), mk(0,0,0,0,1,(z ? 2'd1 : 2'd0),0,2'd0,0,3'd0,0), 1'b1, 1'b0);
        4'd12: push(rb(), mk(0,0,0,0,1,2'd2,0,2'd0,0,3'd0,0), 1'b1, 1'b0);
        4'd13: push(rb(), 15'd0, 1'b1, 1'b0);
        default: begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
          push(rb(), 15'd0, 1'b0, 1'b1);
`else
          push(rb(), mk(0,0,0,0,1,2'd0,0,2'd0,0,3'd0,0), 1'b1, 1'b1);
`endif
        end
      endcase
    end
  endtask

  task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input logic z);
    queue_instr(op, fw, mw, z, 1'b1);
    drain();
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) push(rb(), mk(0,0,0,0,0,2'd0,0,2'd0,0,3'd0,1), 1'b0, 1'b0);
    drain();
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; isaluop = 1'b0; aluop = '0; rd1_zero = 1'b0; mem_ready = 1'b0;
    exp_ret = '0; exp_ill = 1'b0;
    @(negedge clk);
    do_reset(1'b0);

    // zero-wait ALU op 3 back to back
    for (int i = 0; i < 3; i++) run_instr(4'd3, 0, 0, 1'b0);
    // LD with two wait cycles, then branches, jump, LDI, stalled ST
    run_instr(4'd9, 0, 2, 1'b0);
    run_instr(4'd11, 0, 0, 1'b1);
    run_instr(4'd11, 1, 0, 1'b0);
    run_instr(4'd12, 0, 0, 1'b0);
    run_instr(4'd8, 2, 0, 1'b0);
    run_instr(4'd10, 1, 3, 1'b1);

    for (int n = 0; n < 200; n++)
      run_instr(4'($urandom_range(0, 12)), $urandom_range(0, 2), $urandom_range(0, 3), rb());

    // illegal opcode
    run_instr(4'd14, 0, 0, 1'b0);
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    halt_cycles(5);
    do_reset(1'b0);
`else
    run_instr(4'd15, 1, 0, 1'b0);
    run_instr(4'd5, 0, 0, 1'b0);
`endif

    // HALT holds for 20 cycles regardless of mem_ready, then reset restarts fetch
    run_instr(4'd13, 0, 0, 1'b0);
    halt_cycles(20);
    do_reset(1'b1);
    run_instr(4'd1, 0, 0, 1'b0);

    // reset while ST is stalled in MEM with mem_ready high in the reset cycle
    queue_instr(4'd10, 0, 2, 1'b0, 1'b0);
    drain();
    do_reset(1'b1);
    run_instr(4'd2, 0, 0, 1'b0);

    // retire counter wrap
    do_reset(1'b0);
    for (int n = 0; n < (1 << RW); n++) run_instr(4'($urandom_range(0, 7)), 0, 0, 1'b0);
    #1;
    chk("wrap", 32'(retired), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_control.md
# cpu_control

Multi-cycle sequencer for the CPU datapath. It steps each instruction through fetch, decode, execute and memory phases. It uses the opcode/aluop fields from the instruction decoder to drive the instruction-register, PC, register-file, ALU and memory-port controls. It sits between the instruction decoder outputs and the datapath select/enable inputs, and owns the single shared memory port for both instruction fetch and data access.

## Interface
Parameters:
- NIB_WIDTH, 4, width of opcode field (from parameters.v)
- RETIRE_WIDTH, 16, width of retired-instruction counter

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset; synchronous, active-low
- opcode  in  NIB_WIDTH  decoded opcode of the instruction register
- isaluop  in  1  decoder ALU flag (opcode[3]==0)
- aluop  in  3  decoder ALU function
- rd1_zero  in  1  register-file read port 1 (reg1) equals zero
- mem_ready  in  1  memory port completion; valid only while mem_req=1
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe; qualifies mem_req
- mem_addr_sel  out  1  0 = PC address, 1 = reg2 data address
- ir_load  out  1  load instruction register from memory read data
- pc_en  out  1  update PC this cycle
- pc_sel  out  2  0 = PC+1, 1 = PC+signext(bigval), 2 = reg2 data
- reg_we  out  1  register-file write to reg1
- reg_wsel  out  2  write source: 0 = ALU, 1 = bigval, 2 = memory data
- alu_en  out  1  ALU operand capture/operate
- alu_func  out  3  ALU function, equals aluop while alu_en=1, else 0
- halted  out  1  core stopped
- illegal  out  1  sticky illegal-opcode flag
- retired  out  RETIRE_WIDTH  count of completed instructions

## Operation
Opcode map:
- 0–7: ALU, `reg1 <= f(reg2, reg3)`.
- 8: LDI, `reg1 <= bigval`.
- 9: LD, `reg1 <= mem[reg2]`.
- 10: ST, `mem[reg2] <= reg1`.
- 11: BZ, if `reg1 == 0`, `PC += signext(bigval)`.
- 12: JMP, `PC <= reg2`.
- 13: HALT.
- 14–15: illegal.

States:
- FETCH (reset state):
  - Drive mem_req=1 and mem_addr_sel=0.
  - When mem_ready=1, assert ir_load and go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Registers and decoder settle.
  - Go to EXEC. No outputs active.
- EXEC, by opcode:
  - ALU: alu_en=1, alu_func=aluop, reg_we=1, reg_wsel=0, pc_en=1, pc_sel=0. Next state FETCH.
  - LDI: reg_we=1, reg_wsel=1, pc_en=1, pc_sel=0. Next state FETCH.
  - LD/ST: go to MEM. No PC update in EXEC.
  - BZ: pc_en=1, pc_sel=1 when rd1_zero=1, else pc_sel=0. Next state FETCH.
  - JMP: pc_en=1, pc_sel=2. Next state FETCH.
  - HALT: go to HALT. PC is not advanced.
  - Illegal: set illegal=1 (sticky). Behaviour is per the Configuration section.
- MEM:
  - Drive mem_req=1, mem_addr_sel=1, and mem_we=1 for ST.
  - When mem_ready=1: for LD assert reg_we=1 with reg_wsel=2; assert pc_en=1 with pc_sel=0; go to FETCH.
- HALT:
  - halted=1. All strobes stay 0.
  - Only rst_n leaves HALT.

Retire counter:
- retired increments by 1 in every cycle that ends an instruction. These are: any EXEC→FETCH transition, MEM completion, and entry to HALT.
- It wraps modulo 2^RETIRE_WIDTH.

## Timing
- Reset (rst_n=0 at a clock edge) gives:
  - state FETCH;
  - retired=0, illegal=0, halted=0;
  - every strobe and select is 0 in the following cycle.
- mem_req is asserted combinationally from state, so it rises in the first cycle after reset is released.
- Memory handshake:
  - mem_req, mem_we and mem_addr_sel are held constant until the cycle in which mem_ready=1 is sampled. That cycle completes the access.
  - mem_req may be re-asserted in the very next cycle, for a MEM phase or the next FETCH.
  - mem_ready while mem_req=0 is ignored.
- Latency with zero-wait memory (mem_ready=1 in the first request cycle):
  - ALU/LDI/BZ/JMP: 3 cycles (FETCH, DECODE, EXEC).
  - LD/ST: 4 cycles.
  - Each wait cycle on mem_ready adds one cycle.
- Strobes (ir_load, pc_en, reg_we, alu_en) are single-cycle pulses per instruction. They are never asserted in DECODE.
- Reset mid-access (including mid-MEM): the access is abandoned with no reg_we, pc_en or retire. The next cycle is a fresh FETCH.

## Configuration
- CPU_CTRL_ILLEGAL_TRAP_EN defined: an illegal opcode in EXEC goes to HALT without advancing the PC, and retired does not increment.
- CPU_CTRL_ILLEGAL_TRAP_EN undefined: an illegal opcode executes as a NOP (pc_en=1, pc_sel=0, go to FETCH, retired increments).
- illegal is set in both builds.

## Test plan
- Reset, then mem_ready=1 constantly with ALU opcode 3 → mem_req high in cycle 1. ir_load in cycle 1, alu_en with alu_func=3 plus reg_we and pc_en in cycle 3. retired=1 after cycle 3, repeating every 3 cycles.
- LD (opcode 9) with mem_ready held low for 2 cycles in MEM → mem_req, mem_addr_sel=1 and mem_we=0 are held stable for 3 cycles. reg_we=1 with reg_wsel=2 only in the ready cycle.
- BZ with rd1_zero=1 → pc_sel=1. BZ with rd1_zero=0 → pc_sel=0. JMP → pc_sel=2. Each is a single pc_en pulse.
- HALT (opcode 13) → halted=1 and all strobes 0 for 20 cycles while mem_ready toggles. rst_n=0 for one cycle → FETCH resumes with retired=0.
- Opcode 14 → illegal=1. With the macro: halted=1, retired unchanged. Without the macro: NOP, retired +1, fetch continues.
- rst_n=0 during a stalled ST → no reg_we, pc_en or retire. Next cycle mem_req=1 with mem_addr_sel=0. Also run 2^16 instructions and check retired wraps to 0.
